haze_recover_pipe: RTL and testbench

//  Parametrised scene-radiance recovery stage J = A + (I - A)*(2^T_W-1)/max(t,T0), for CHANNELS colour channels of DATA_W bits.

---
 rtl/haze_pkg.sv | 18 +
 rtl/haze_recip_lut.sv | 27 ++
 rtl/haze_recover_pipe.sv | 179 +++++++++++++++++
 tb/tb_haze_recover_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/haze_pkg.sv
// Shared defaults, pipeline latency and the reciprocal used to fill the transmission LUT.
package haze_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int T_W_DEF    = 8;
  localparam int F_DEF      = 8;
  localparam int LAT        = 6;

  // round((2^t_w - 1) * 2^f / t); t = 0 is never addressed, it gets the t = 1 value
  function automatic int unsigned recip_val(input int unsigned t, input int unsigned t_w,
                                            input int unsigned f);
    int unsigned num;
    num = ((32'd1 << t_w) - 32'd1) << f;
    if (t == 0) return num;
    return (num + t / 2) / t;
  endfunction

endpackage

// File: rtl/haze_recip_lut.sv
// Registered reciprocal ROM indexed by floored transmission, one cycle read latency.
module haze_recip_lut
  import haze_pkg::*;
#(
  parameter int T_W = T_W_DEF,
  parameter int F   = F_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [T_W-1:0]   addr,
  output logic [T_W+F-1:0] recip
);

  localparam int RW = T_W + F;

  logic [RW-1:0] rom [2**T_W];

  for (genvar i = 0; i < 2**T_W; i++) begin : g_rom
    assign rom[i] = RW'(recip_val(unsigned'(i), T_W, F));
  end

  always_ff @(posedge clk) begin
    if (rst) recip <= '0;
    else     recip <= rom[addr];
  end

endmodule

// File: rtl/haze_recover_pipe.sv
// Haze radiance recovery J = A + (I-A)*(2^T_W-1)/max(t,T0); fixed 6-cycle latency, free-running, no stall.
// HAZE_Y_BOOST_EN adds Y_BOOST to every channel ahead of the clip.
module haze_recover_pipe
  import haze_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CHANNELS = 3,
  parameter int T_W      = T_W_DEF,
  parameter int F        = F_DEF,
  parameter int T0       = 26,
  parameter int A_INIT   = 240,
  parameter int CNT_W    = 20,
  parameter int Y_BOOST  = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pre_frame_vsync,
  input  logic                         pre_frame_href,
  input  logic                         pre_frame_clken,
  input  logic [CHANNELS*DATA_W-1:0]   pre_img,
  input  logic [T_W-1:0]               pre_tx,
  input  logic [DATA_W-1:0]            pre_A,
  input  logic                         a_valid,
  input  logic                         bypass,
  output logic                         post_frame_vsync,
  output logic                         post_frame_href,
  output logic                         post_frame_clken,
  output logic [CHANNELS*DATA_W-1:0]   post_img,
  output logic [CNT_W-1:0]             sat_count,
  output logic                         sat_count_vld
);

  localparam int RECIP_W = T_W + F;
  localparam int PW      = DATA_W + RECIP_W + 2;
  localparam int IW      = CHANNELS * DATA_W;
`ifdef HAZE_Y_BOOST_EN
  localparam int BOOST_EN = 1;
`else
  localparam int BOOST_EN = 0;
`endif
  localparam logic signed [PW:0]   BOOST   = (PW+1)'(Y_BOOST * BOOST_EN);
  localparam logic signed [PW-1:0] HALF    = PW'(2 ** (F - 1));
  localparam logic signed [PW:0]   PIX_MAX = (PW+1)'(2 ** DATA_W - 1);
  localparam logic [T_W-1:0]       T_FLOOR = T_W'(T0);

  // primed keeps a vsync that is already high at reset release from counting as a frame start
  logic              vsync_q, primed, frame_rise, byp_frame, byp_cur;
  logic [DATA_W-1:0] a_frame, a_cur;

  always_comb begin
    frame_rise = primed && pre_frame_vsync && !vsync_q;
    a_cur      = (frame_rise && a_valid) ? pre_A : a_frame;
    byp_cur    = frame_rise ? bypass : byp_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      primed    <= 1'b0;
      a_frame   <= DATA_W'(A_INIT);
      byp_frame <= 1'b0;
    end else begin
      vsync_q   <= pre_frame_vsync;
      primed    <= 1'b1;
      a_frame   <= a_cur;
      byp_frame <= byp_cur;
    end
  end

  logic [IW-1:0]             img_q [5];
  logic [DATA_W-1:0]         a_q [4];
  logic [4:0]                byp_q;
  logic [T_W-1:0]            tc_q;
  logic [RECIP_W-1:0]        recip_s1, recip_s2;
  logic signed [DATA_W:0]    diff_d [CHANNELS], diff_q [CHANNELS];
  logic signed [PW-1:0]      prod_d [CHANNELS], prod_q [CHANNELS];
  logic signed [PW:0]        sum_d  [CHANNELS], sum_q  [CHANNELS];
  logic signed [PW-1:0]      q_t;
  logic signed [PW:0]        v_t;
  logic [IW-1:0]             clip_d;
  logic                      clip_any;

  haze_recip_lut #(.T_W(T_W), .F(F)) u_recip (
    .clk   (clk),
    .rst   (rst),
    .addr  (tc_q),
    .recip (recip_s1)
  );

  always_comb begin
    clip_d   = '0;
    clip_any = 1'b0;
    q_t      = '0;
    v_t      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff_d[c] = $signed({1'b0, img_q[1][c*DATA_W +: DATA_W]}) - $signed({1'b0, a_q[1]});
      prod_d[c] = PW'(diff_q[c]) * $signed({{(PW-RECIP_W){1'b0}}, recip_s2});
      q_t       = (prod_q[c] + HALF) >>> F;
      sum_d[c]  = (PW+1)'(q_t) + $signed({{(PW+1-DATA_W){1'b0}}, a_q[3]});
      v_t       = sum_q[c] + BOOST;
      if (v_t < 0) begin
        clip_any = 1'b1;
      end else if (v_t > PIX_MAX) begin
        clip_d[c*DATA_W +: DATA_W] = '1;
        clip_any = 1'b1;
      end else begin
        clip_d[c*DATA_W +: DATA_W] = v_t[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) img_q[k] <= '0;
      for (int k = 0; k < 4; k++) a_q[k] <= '0;
      byp_q    <= '0;
      tc_q     <= '0;
      recip_s2 <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        diff_q[c] <= '0;
        prod_q[c] <= '0;
        sum_q[c]  <= '0;
      end
    end else begin
      img_q[0] <= pre_img;
      for (int k = 1; k < 5; k++) img_q[k] <= img_q[k-1];
      a_q[0] <= a_cur;
      for (int k = 1; k < 4; k++) a_q[k] <= a_q[k-1];
      byp_q    <= {byp_q[3:0], byp_cur};
      tc_q     <= (pre_tx < T_FLOOR) ? T_FLOOR : pre_tx;
      recip_s2 <= recip_s1;
      diff_q   <= diff_d;
      prod_q   <= prod_d;
      sum_q    <= sum_d;
    end
  end

  logic [2:0] sync_sr [LAT];
  logic       post_sat, post_vs_q, vs_fall;
  logic [CNT_W-1:0] run_cnt, run_next;

  assign post_frame_vsync = sync_sr[LAT-1][2];
  assign post_frame_href  = sync_sr[LAT-1][1];
  assign post_frame_clken = sync_sr[LAT-1][0];

  always_comb begin
    vs_fall  = post_vs_q && !post_frame_vsync;
    run_next = run_cnt;
    if (post_frame_clken && post_sat && (run_cnt != {CNT_W{1'b1}}))
      run_next = run_cnt + 1'b1;
  end

  // the frame-closing pixel is folded in through run_next before the count is published
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) sync_sr[k] <= '0;
      post_img      <= '0;
      post_sat      <= 1'b0;
      post_vs_q     <= 1'b0;
      run_cnt       <= '0;
      sat_count     <= '0;
      sat_count_vld <= 1'b0;
    end else begin
      sync_sr[0] <= {pre_frame_vsync, pre_frame_href, pre_frame_clken};
      for (int k = 1; k < LAT; k++) sync_sr[k] <= sync_sr[k-1];
      post_img      <= byp_q[4] ? img_q[4] : clip_d;
      post_sat      <= !byp_q[4] && clip_any;
      post_vs_q     <= post_frame_vsync;
      sat_count_vld <= vs_fall;
      if (vs_fall) begin
        sat_count <= run_next;
        run_cnt   <= '0;
      end else begin
        run_cnt   <= run_next;
      end
    end
  end

endmodule

// File: tb/tb_haze_recover_pipe.sv
// Randomized scoreboard bench for haze_recover_pipe with a frame-level arithmetic reference model.
module tb_haze_recover_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        pre_frame_vsync, pre_frame_href, pre_frame_clken;
  logic [23:0] pre_img;
  logic [7:0]  pre_tx, pre_A;
  logic        a_valid, bypass;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [23:0] post_img;
  logic [19:0] sat_count;
  logic        sat_count_vld;

  haze_recover_pipe dut (
    .clk              (clk),
    .rst              (rst),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_href   (pre_frame_href),
    .pre_frame_clken  (pre_frame_clken),
    .pre_img          (pre_img),
    .pre_tx           (pre_tx),
    .pre_A            (pre_A),
    .a_valid          (a_valid),
    .bypass           (bypass),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img         (post_img),
    .sat_count        (sat_count),
    .sat_count_vld    (sat_count_vld)
  );

  always #5 clk = ~clk;

`ifdef HAZE_Y_BOOST_EN
  localparam int BOOST = 30;
`else
  localparam int BOOST = 0;
`endif

  typedef struct { logic [23:0] img; int cyc; } exp_t;

  exp_t exp_q[$];
  int   sat_q[$];
  int   errors = 0, checks = 0, cyc = 0;
  int   m_A = 240, m_cnt = 0;
  bit   m_byp = 0, last_vs = 0, vld_prev = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic logic [23:0] model_pix(input logic [23:0] img, input int t, input int a,
                                            input bit byp, output bit sat);
    logic [23:0] r;
    int tc, rc, j;
    sat = 0;
    r   = img;
    if (!byp) begin
      tc = (t < 26) ? 26 : t;
      rc = (255 * 256 + tc / 2) / tc;
      for (int ch = 0; ch < 3; ch++) begin
        j = a + fdiv((int'(img[ch*8 +: 8]) - a) * rc + 128, 256) + BOOST;
        if (j < 0) begin j = 0; sat = 1; end
        else if (j > 255) begin j = 255; sat = 1; end
        r[ch*8 +: 8] = j[7:0];
      end
    end
    return r;
  endfunction

  // one input cycle; the model tracks frame boundaries from what it drives
  task automatic step(input bit vs, input bit ck, input logic [23:0] img, input logic [7:0] t);
    exp_t e;
    bit   sat;
    @(posedge clk);
    #1;
    pre_frame_vsync = vs;
    pre_frame_href  = ck;
    pre_frame_clken = ck;
    pre_img         = img;
    pre_tx          = t;
    if (vs && !last_vs) begin
      if (a_valid) m_A = int'(pre_A);
      m_byp = bypass;
    end
    if (!vs && last_vs) begin
      sat_q.push_back(m_cnt);
      m_cnt = 0;
    end
    last_vs = vs;
    if (ck) begin
      e.img = model_pix(img, int'(t), m_A, m_byp, sat);
      e.cyc = cyc;
      exp_q.push_back(e);
      if (sat && m_cnt < 20'hFFFFF) m_cnt++;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pre_frame_clken = 1'b0;
    pre_frame_href  = 1'b0;
    exp_q.delete();
    sat_q.delete();
    m_A = 240; m_byp = 0; m_cnt = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_post_img", post_img, 0);
    check("rst_post_vsync", post_frame_vsync, 0);
    check("rst_post_href", post_frame_href, 0);
    check("rst_post_clken", post_frame_clken, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_sat_vld", sat_count_vld, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic frame(input int npix, input bit rnd, input logic [23:0] fimg, input logic [7:0] ft,
                       input logic [7:0] a0, input bit av0, input bit b0,
                       input logic [7:0] a1, input bit av1, input bit b1);
    logic [23:0] img;
    logic [7:0]  t;
    pre_A = a0; a_valid = av0; bypass = b0;
    step(1, 0, 24'h0, 8'h0);
    for (int n = 0; n < npix; n++) begin
      if (n == npix / 2) begin pre_A = a1; a_valid = av1; bypass = b1; end
      img = rnd ? 24'($urandom) : fimg;
      t   = rnd ? (($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom)) : ft;
      if (rnd && $urandom_range(0, 3) == 0) step(1, 0, img, t);
      step(1, 1, img, t);
    end
    step(0, 0, 24'h0, 8'h0);
    repeat (10) step(0, 0, 24'h0, 8'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (post_frame_clken) begin
        if (exp_q.size() == 0) fail("unexpected_pixel");
        else begin
          mon_e = exp_q.pop_front();
          check("post_img", post_img, mon_e.img);
          check("latency", cyc - mon_e.cyc, 6);
        end
      end
      if (vld_prev) check("vld_pulse_width", sat_count_vld, 0);
      if (sat_count_vld) begin
        if (sat_q.size() == 0) fail("unexpected_sat_vld");
        else check("sat_count", sat_count, sat_q.pop_front());
      end
    end
    vld_prev = sat_count_vld;
  end

  initial begin
    #500000;
    fail("timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    pre_frame_vsync = 0; pre_frame_href = 0; pre_frame_clken = 0;
    pre_img = '0; pre_tx = '0; pre_A = '0; a_valid = 0; bypass = 0;
    do_reset(3);
    repeat (3) step(0, 0, 24'h0, 8'h0);

    frame(4, 0, {3{8'd210}}, 8'd255, 8'd200, 1, 0, 8'd200, 1, 0);
    frame(4, 0, {3{8'd100}}, 8'd128, 8'd200, 1, 0, 8'd200, 1, 0);
    frame(5, 0, {3{8'd100}}, 8'd10,  8'd200, 1, 0, 8'd200, 1, 0);
    frame(4, 0, {3{8'd210}}, 8'd128, 8'd200, 1, 0, 8'd150, 1, 0);
    frame(4, 0, {3{8'd210}}, 8'd128, 8'd150, 1, 0, 8'd150, 1, 0);
    frame(4, 0, {3{8'd210}}, 8'd128, 8'd50,  0, 0, 8'd60,  0, 0);
    frame(6, 1, 24'h0, 8'h0, 8'd200, 1, 0, 8'd200, 1, 1);
    frame(6, 1, 24'h0, 8'h0, 8'd200, 1, 1, 8'd200, 1, 1);
    frame(4, 1, 24'h0, 8'h0, 8'd200, 1, 0, 8'd200, 1, 0);
    frame(3, 0, {3{8'd240}}, 8'd255, 8'd200, 1, 0, 8'd200, 1, 0);

    repeat (6)
      frame($urandom_range(4, 20), 1, 24'h0, 8'h0,
            8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);

    // reset in the middle of a frame; vsync stays high so the rest of it keeps A_INIT
    pre_A = 8'd180; a_valid = 1; bypass = 0;
    step(1, 0, 24'h0, 8'h0);
    repeat (5) step(1, 1, 24'($urandom), 8'($urandom));
    do_reset(2);
    repeat (6) begin
      step(1, 0, 24'h0, 8'h0);
      @(negedge clk);
      check("flush_clken", post_frame_clken, 0);
    end
    repeat (6) step(1, 1, 24'($urandom), 8'($urandom_range(0, 60)));
    step(0, 0, 24'h0, 8'h0);
    repeat (10) step(0, 0, 24'h0, 8'h0);

    frame(6, 1, 24'h0, 8'h0, 8'd100, 1, 0, 8'd20, 1, 1);

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && sat_q.size() == 0) break;
      step(0, 0, 24'h0, 8'h0);
    end
    check("drain_pixels", exp_q.size(), 0);
    check("drain_sat", sat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
